// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF synchroniser, mid-bit sampling with false-start
// rejection, optional parity, 1 or 2 stop bits, valid/ready output with overrun flag.
`timescale 1ns/1ps

module uart_rx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state, state_next;
  logic                 sync1, rxs;
  logic [TW-1:0]        timer, timer_next;
  logic [BW-1:0]        bitcnt, bit_next;
  logic [DATA_BITS-1:0] shreg, shreg_next;
  logic                 par_bad, par_bad_next;
  logic                 stop_bad, stop_bad_next;
  logic                 frame_done;
  logic                 xfer;

  // Both synchroniser flops reset high so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples
      // the pre-edge values, independent of statement order.
      sync1 <= rx_in;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      timer    <= '0;
      bitcnt   <= '0;
      shreg    <= '0;
      par_bad  <= 1'b0;
      stop_bad <= 1'b0;
    end else begin
      state    <= state_next;
      timer    <= timer_next;
      bitcnt   <= bit_next;
      shreg    <= shreg_next;
      par_bad  <= par_bad_next;
      stop_bad <= stop_bad_next;
    end
  end

  // Sample decisions land at t0+2+H+j*CLKS_PER_BIT (j = bits after start), so the
  // last stop sample and the rx_valid load happen one cycle ahead of the nominal
  // t0+3+H+K*CLKS_PER_BIT point, inside the permitted one-cycle slack.
  always_comb begin
    // NOTE: every output of this block is given a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    state_next    = state;
    timer_next    = timer;
    bit_next      = bitcnt;
    shreg_next    = shreg;
    par_bad_next  = par_bad;
    stop_bad_next = stop_bad;
    frame_done    = 1'b0;

    case (state)
      S_IDLE: begin
        if (!rxs) begin
          timer_next = '0;
          state_next = S_START;
        end
      end

      S_START: begin
        if (timer == HALF_LAST) begin
          if (rxs) begin
            state_next = S_IDLE;
          end else begin
            timer_next    = '0;
            bit_next      = '0;
            par_bad_next  = 1'b0;
            stop_bad_next = 1'b0;
            state_next    = S_DATA;
          end
        end else begin
          timer_next = timer + 1'b1;
        end
      end

      S_DATA: begin
        if (timer == BIT_LAST) begin
          timer_next = '0;
          shreg_next = {rxs, shreg[DATA_BITS-1:1]};
          if (bitcnt == DATA_LAST) begin
            bit_next   = '0;
            state_next = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_next = bitcnt + 1'b1;
          end
        end else begin
          timer_next = timer + 1'b1;
        end
      end

      S_PARITY: begin
        if (timer == BIT_LAST) begin
          timer_next   = '0;
          par_bad_next = (PARITY == 2) ? ~(^shreg ^ rxs) : (^shreg ^ rxs);
          state_next   = S_STOP;
        end else begin
          timer_next = timer + 1'b1;
        end
      end

      S_STOP: begin
        if (timer == BIT_LAST) begin
          timer_next    = '0;
          stop_bad_next = stop_bad | ~rxs;
          if (bitcnt == STOP_LAST) begin
            // Return to IDLE mid-stop-bit so a back-to-back start edge is not missed.
            bit_next   = '0;
            frame_done = 1'b1;
            state_next = S_IDLE;
          end else begin
            bit_next = bitcnt + 1'b1;
          end
        end else begin
          timer_next = timer + 1'b1;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  assign xfer = rx_valid && rx_ready;
  assign busy = (state != S_IDLE);

  // A frame finishing while an untaken word is held is dropped and flagged;
  // one finishing on a transfer cycle replaces the word being consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (xfer) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
      if (frame_done) begin
        if (!rx_valid || xfer) begin
          rx_data    <= shreg;
          parity_err <= par_bad;
          frame_err  <= stop_bad_next;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: four configurations driven from a bit-level
// line model, with expected words and flags computed from the frame rules.
`timescale 1ns/1ps

module tb_uart_rx_param;

  localparam int CPB = 16;
  localparam int H   = CPB / 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_line [4];
  logic       rdy     [4];
  logic [7:0] d0, d1;
  logic [4:0] d2;
  logic [8:0] d3;
  logic       v  [4];
  logic       pe [4];
  logic       fe [4];
  logic       ov [4];
  logic       bz [4];

  always #5 clk = ~clk;

  uart_rx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .rx_in(rx_line[0]), .rx_ready(rdy[0]), .rx_data(d0),
    .rx_valid(v[0]), .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]), .busy(bz[0]));

  uart_rx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(reset), .rx_in(rx_line[1]), .rx_ready(rdy[1]), .rx_data(d1),
    .rx_valid(v[1]), .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]), .busy(bz[1]));

  uart_rx_param #(.DATA_BITS(5), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2)) u2 (
    .clk(clk), .reset(reset), .rx_in(rx_line[2]), .rx_ready(rdy[2]), .rx_data(d2),
    .rx_valid(v[2]), .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]), .busy(bz[2]));

  uart_rx_param #(.DATA_BITS(9), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2)) u3 (
    .clk(clk), .reset(reset), .rx_in(rx_line[3]), .rx_ready(rdy[3]), .rx_data(d3),
    .rx_valid(v[3]), .parity_err(pe[3]), .frame_err(fe[3]), .overrun(ov[3]), .busy(bz[3]));

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       pe;
    logic       fe;
    int         cyc;
  } rec_t;

  rec_t xfers[$];
  int   cyc = 0;
  int   vcnt [4] = '{0, 0, 0, 0};
  int   n_checks = 0;
  int   n_fail = 0;
  int   last_t0 = 0;

  // Transfer monitor: sees pre-edge values, records each accepted word with its edge index.
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 4; i++) if (v[i] === 1'b1) vcnt[i]++;
    if (v[0] && rdy[0]) xfers.push_back('{0, {1'b0, d0}, pe[0], fe[0], cyc});
    if (v[1] && rdy[1]) xfers.push_back('{1, {1'b0, d1}, pe[1], fe[1], cyc});
    if (v[2] && rdy[2]) xfers.push_back('{2, {4'b0, d2}, pe[2], fe[2], cyc});
    if (v[3] && rdy[3]) xfers.push_back('{3, d3, pe[3], fe[3], cyc});
  end

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
    end
  endtask

  // Parity bit that makes the frame correct for the given mode (1 even, 2 odd).
  function automatic logic good_par(input logic [8:0] data, input int pmode);
    int ones;
    ones = $countones(data);
    if (pmode == 1) return (ones % 2) != 0;
    return (ones % 2) == 0;
  endfunction

  // Expected {frame_err, parity_err, data} for a frame built from these fields.
  function automatic logic [10:0] model(input logic [8:0] word, input int nbits, input int pmode,
                                        input logic pbit, input logic stop_val);
    logic [8:0] data;
    int         total;
    logic       p_err;
    data  = word & 9'((1 << nbits) - 1);
    total = $countones(data) + int'(pbit);
    if (pmode == 1)      p_err = (total % 2) == 1;
    else if (pmode == 2) p_err = (total % 2) == 0;
    else                 p_err = 1'b0;
    return {~stop_val, p_err, data};
  endfunction

  task automatic send_frame(input int inst, input logic [8:0] word, input int nbits, input int pmode,
                            input logic pbit, input int nstop, input logic stop_val,
                            input real bit_ns, input bit align);
    if (align) begin
      @(posedge clk);
      #2;
    end
    last_t0 = cyc + 1;
    rx_line[inst] = 1'b0;
    #(bit_ns);
    for (int i = 0; i < nbits; i++) begin
      rx_line[inst] = word[i];
      #(bit_ns);
    end
    if (pmode != 0) begin
      rx_line[inst] = pbit;
      #(bit_ns);
    end
    for (int i = 0; i < nstop; i++) begin
      rx_line[inst] = stop_val;
      #(bit_ns);
    end
    rx_line[inst] = 1'b1;
  endtask

  task automatic expect_rec(input string tag, input int inst, input logic [10:0] exp);
    int   waited;
    rec_t r;
    waited = 0;
    while (xfers.size() == 0 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_arrived"}, 32'(xfers.size() != 0), 1);
    if (xfers.size() != 0) begin
      r = xfers.pop_front();
      check({tag, "_inst"}, r.inst, inst);
      check({tag, "_data"}, r.data, exp[8:0]);
      check({tag, "_perr"}, r.pe, exp[9]);
      check({tag, "_ferr"}, r.fe, exp[10]);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  int         t0a, lat, vc0, t0g, t0h, e_edge, nb;
  logic [8:0] w;
  logic       pb;
  real        scale;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_line[i] = 1'b1;
      rdy[i]     = 1'b1;
    end
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state on every instance
    check("rst_data0", d0, 0);
    check("rst_data3", d3, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_valid%0d", i), v[i], 0);
      check($sformatf("rst_perr%0d", i), pe[i], 0);
      check($sformatf("rst_ferr%0d", i), fe[i], 0);
      check($sformatf("rst_ovr%0d", i), ov[i], 0);
      check($sformatf("rst_busy%0d", i), bz[i], 0);
    end

    // Back-to-back frames, exact bit period
    xfers.delete();
    vc0 = vcnt[0];
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1, 160.0, 1'b1);
    t0a = last_t0;
    send_frame(0, 9'h03C, 8, 0, 1'b0, 1, 1'b1, 160.0, 1'b0);
    repeat (20) @(negedge clk);
    check("basic_count", xfers.size(), 2);
    check("basic_valid_cycles", vcnt[0] - vc0, 2);
    lat = 2 + H + 9 * CPB;
    if (xfers.size() == 2) begin
      lat = xfers[0].cyc - 1 - t0a;
      check("basic_latency_window", 32'(lat >= 2 + H + 9 * CPB && lat <= 4 + H + 9 * CPB), 1);
      check("basic_spacing", xfers[1].cyc - xfers[0].cyc, 160);
    end
    expect_rec("basic0", 0, model(9'h0A5, 8, 0, 1'b0, 1'b1));
    expect_rec("basic1", 0, model(9'h03C, 8, 0, 1'b0, 1'b1));

    // Odd parity: directed pair, then random words with random parity corruption
    send_frame(1, 9'h007, 8, 2, 1'b0, 1, 1'b1, 160.0, 1'b1);
    expect_rec("par_ok", 1, model(9'h007, 8, 2, 1'b0, 1'b1));
    send_frame(1, 9'h007, 8, 2, 1'b1, 1, 1'b1, 160.0, 1'b1);
    expect_rec("par_bad", 1, model(9'h007, 8, 2, 1'b1, 1'b1));
    for (int k = 0; k < 6; k++) begin
      w  = 9'($urandom_range(0, 255));
      pb = good_par(w, 2) ^ 1'($urandom_range(0, 1));
      send_frame(1, w, 8, 2, pb, 1, 1'b1, 160.0, 1'b1);
      expect_rec($sformatf("par_rand%0d", k), 1, model(w, 8, 2, pb, 1'b1));
    end

    // Stop bit driven low; the trailing low line would start a new frame, so reset after
    send_frame(0, 9'h055, 8, 0, 1'b0, 1, 1'b0, 160.0, 1'b1);
    expect_rec("frame_err", 0, model(9'h055, 8, 0, 1'b0, 1'b0));
    do_reset(3);
    xfers.delete();
    repeat (5) @(negedge clk);

    // Short low glitch on an idle line is a false start
    vc0 = vcnt[0];
    @(posedge clk);
    #2;
    t0g = cyc + 1;
    rx_line[0] = 1'b0;
    #50;
    rx_line[0] = 1'b1;
    while (cyc < t0g + 3) @(negedge clk);
    check("glitch_busy_rise", bz[0], 1);
    while (cyc < t0g + H + 4) @(negedge clk);
    check("glitch_busy_fall", bz[0], 0);
    repeat (200) @(negedge clk);
    check("glitch_no_valid", vcnt[0] - vc0, 0);
    check("glitch_no_xfer", xfers.size(), 0);

    // Reset mid-frame abandons it; the line stays idle afterwards
    vc0 = vcnt[0];
    @(posedge clk);
    #2;
    rx_line[0] = 1'b0;
    #160;
    rx_line[0] = 1'b1;
    repeat (30) @(negedge clk);
    check("midrst_busy_before", bz[0], 1);
    do_reset(2);
    check("midrst_busy_after", bz[0], 0);
    repeat (250) @(negedge clk);
    check("midrst_no_valid", vcnt[0] - vc0, 0);
    w = 9'($urandom_range(0, 255));
    send_frame(0, w, 8, 0, 1'b0, 1, 1'b1, 160.0, 1'b1);
    expect_rec("post_rst", 0, model(w, 8, 0, 1'b0, 1'b1));

    // Backpressure and overrun
    @(negedge clk);
    rdy[0] = 1'b0;
    xfers.delete();
    send_frame(0, 9'h011, 8, 0, 1'b0, 1, 1'b1, 160.0, 1'b1);
    send_frame(0, 9'h022, 8, 0, 1'b0, 1, 1'b1, 160.0, 1'b0);
    repeat (10) @(negedge clk);
    check("ovr_data_held", d0, 8'h11);
    check("ovr_valid", v[0], 1);
    check("ovr_flag", ov[0], 1);
    check("ovr_no_xfer", xfers.size(), 0);
    @(negedge clk);
    rdy[0] = 1'b1;
    @(negedge clk);
    rdy[0] = 1'b0;
    check("ovr_valid_drop", v[0], 0);
    check("ovr_flag_drop", ov[0], 0);
    expect_rec("ovr_xfer", 0, model(9'h011, 8, 0, 1'b0, 1'b1));

    send_frame(0, 9'h033, 8, 0, 1'b0, 1, 1'b1, 160.0, 1'b1);
    repeat (4) @(negedge clk);
    check("hold_valid", v[0], 1);
    check("hold_no_ovr", ov[0], 0);

    // Next frame completes exactly on the cycle the held word is taken
    @(posedge clk);
    #2;
    t0h    = cyc + 1;
    e_edge = t0h + lat;
    fork
      send_frame(0, 9'h044, 8, 0, 1'b0, 1, 1'b1, 160.0, 1'b0);
      begin
        while (cyc < e_edge - 1) @(negedge clk);
        rdy[0] = 1'b1;
        @(negedge clk);
        rdy[0] = 1'b0;
        check("same_cycle_valid", v[0], 1);
        check("same_cycle_data", d0, 8'h44);
        check("same_cycle_ovr", ov[0], 0);
      end
    join
    @(negedge clk);
    rdy[0] = 1'b1;
    expect_rec("same_cycle_first", 0, model(9'h033, 8, 0, 1'b0, 1'b1));
    expect_rec("same_cycle_second", 0, model(9'h044, 8, 0, 1'b0, 1'b1));

    // Sweep: 5- and 9-bit words, even parity, two stop bits, +/-3% baud error
    for (int inst = 2; inst < 4; inst++) begin
      nb = (inst == 2) ? 5 : 9;
      for (int k = 0; k < 6; k++) begin
        w     = 9'($urandom_range(0, (1 << nb) - 1));
        pb    = good_par(w, 1);
        scale = (k % 2 == 0) ? 0.97 : 1.03;
        send_frame(inst, w, nb, 1, pb, 2, 1'b1, 160.0 * scale, 1'b1);
        expect_rec($sformatf("sweep%0d_%0d", inst, k), inst, model(w, nb, 1, pb, 1'b1));
        repeat (32) @(negedge clk);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver: it recovers serial frames from an asynchronous line into a parallel word. Data width, parity mode, stop-bit count and baud divisor are all configurable. It adds a valid/ready output handshake, mid-bit sampling with false-start rejection, and parity, framing and overrun error reporting. It sits between the board RX pin and the packet/command layer, alongside the existing UART transmitter.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5..9, sent LSB first.
- `CLKS_PER_BIT`, 868: clk cycles per bit period, min 4. 868 gives 115200 baud at 100 MHz.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `rx_in`  in  1  asynchronous serial line, idle high.
- `rx_ready`  in  1  consumer accepts `rx_data` when high with `rx_valid`.
- `rx_data`  out  DATA_BITS  received word.
- `rx_valid`  out  1  `rx_data` and error flags are valid.
- `parity_err`  out  1  parity mismatch on held word; always 0 when PARITY=0.
- `frame_err`  out  1  a stop bit sampled 0 on held word.
- `overrun`  out  1  at least one frame was dropped while `rx_valid` was pending.
- `busy`  out  1  FSM not in IDLE.

## Operation
- **Input synchronisation:** `rx_in` passes through a 2-FF synchroniser. Both flops reset to 1. All decisions use the synchronised value `rxs`.
- **Counters:**
  - Bit-timer width `$clog2(CLKS_PER_BIT)`.
  - H = `CLKS_PER_BIT/2`, floor.
  - Bit counter width `$clog2(DATA_BITS+1)`.
- **FSM states and transitions:**
  - IDLE: on `rxs`==0, clear timer and go to START.
  - START: count H cycles, then sample. If `rxs`==1, this is a false start: go to IDLE, with no output or flag change. Otherwise clear timer and bit counter, then go to DATA.
  - DATA: sample every `CLKS_PER_BIT` cycles and shift into the shift register LSB-first. After DATA_BITS samples, go to PARITY if PARITY≠0, else to STOP.
  - PARITY: sample one bit after `CLKS_PER_BIT` cycles.
    - Even mode: error if XOR(data, parity bit) = 1.
    - Odd mode: error if that XOR = 0.
  - STOP: sample STOP_BITS bits, each `CLKS_PER_BIT` apart. Any 0 sets the frame error.
    - After the last stop sample, go straight to IDLE. The FSM does not wait out the rest of the stop bit, so back-to-back frames are received.
- **Output register:** loaded on the cycle of the last stop sample, with `rx_data`, `parity_err` and `frame_err` loaded together. `rx_valid` is set the same cycle.
  - Errored frames are still delivered, with their flags set.
- **Handshake:** a transfer occurs on any cycle with `rx_valid`&&`rx_ready`.
  - `rx_valid` clears the following cycle unless a new frame loads in that same cycle.
  - `rx_data` and the error flags stay stable while `rx_valid`=1 and no transfer occurs.
- **Overrun:**
  - A frame completing while `rx_valid`=1 and no transfer occurs that cycle is discarded; the held word is untouched. `overrun` is set to 1.
  - A frame completing in the same cycle as a transfer is loaded normally, with no overrun.
  - `overrun` is sticky and clears on the next transfer.
- **Reset:** every cycle `reset` is high forces the following:
  - FSM goes to IDLE, and timer, bit counter and shift register go to 0.
  - Synchroniser flops go to 1.
  - `rx_data`=0, and `rx_valid`, `parity_err`, `frame_err`, `overrun` and `busy` go to 0.
  - Reset mid-frame abandons the frame. Reception resumes at the next falling edge seen after `reset` deasserts.

## Timing
- Let t0 = first posedge at which `rx_in` is sampled low. Then `rxs`=0 at t0+2, and `busy`=1 from t0+3.
- Let K = DATA_BITS + (PARITY≠0) + STOP_BITS. The last stop sample, and the rise of `rx_valid`, occur at t0 + 3 + H + K·`CLKS_PER_BIT`, ±1 cycle of implementation slack that must be documented in RTL.
- Sample points are exactly `CLKS_PER_BIT` apart, with the first data sample H+`CLKS_PER_BIT` after START entry.
- Tolerated baud mismatch is ±(H-2)/(K+0.5)/`CLKS_PER_BIT`. Beyond that, frame errors are expected.
- Throughput is one word per frame time. With `rx_ready` tied high, no overrun occurs at full line rate.

## Test plan
Bench uses `CLKS_PER_BIT`=16, DATA_BITS=8 and an exact bit period unless stated.
- Reset: after reset, all outputs are 0 and `busy`=0. Assert `reset` mid-frame: the FSM returns to IDLE and no `rx_valid` follows. The next clean frame is received correctly.
- Basic frames: PARITY=0, STOP_BITS=1, send 0xA5 then 0x3C back-to-back with `rx_ready`=1.
  - `rx_data`=0xA5 then 0x3C, each `rx_valid` for exactly 1 cycle.
  - The two rises are exactly 160 cycles apart, with no error flags.
- Parity: PARITY=2 (odd).
  - 0x07 with parity bit 0 → `parity_err`=0.
  - 0x07 with parity bit 1 → `parity_err`=1 and `rx_data`=0x07 still delivered.
- Framing and false start:
  - Stop bit driven 0 on 0x55 → `frame_err`=1.
  - A 5-cycle low glitch on idle line → no `rx_valid`, `busy` returns to 0 within H+4 cycles.
- Overrun and backpressure: hold `rx_ready`=0 and send 0x11, 0x22.
  - `rx_data` stays 0x11, `overrun`=1 after the second frame.
  - Pulse `rx_ready` → `rx_valid` and `overrun` drop the next cycle.
  - Also check a frame completing on the transfer cycle loads with `overrun`=0.
- Configuration sweep: DATA_BITS ∈ {5,9}, STOP_BITS=2, PARITY=1, with ±3% baud error on randomised words.
  - Every word matches the sent value and all error flags are 0.
